// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

   // Controller sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Widest operand the controller is intended to be built for
   localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_add_fa_cell.sv
// Single-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // Sum and carry of one bit position
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | ((a ^ b) & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell walked LSB first over WIDTH cycles.
// Optional subtract mode is compiled in with the SERIAL_ADD_SUB_EN macro.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [CW-1:0]    count;
   logic             carry;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             accept;
   logic             step;
   logic             last;
   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] b_load;
   logic             carry_init;

`ifdef SERIAL_ADD_SUB_EN
   // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1
   assign b_load     = sub ? ~b : b;
   assign carry_init = sub;
`else
   assign b_load     = b;
   assign carry_init = 1'b0;
`endif

   fa_cell u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and datapath strobes; start is only looked at in IDLE
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (count == LAST_BIT) begin
               last       = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Operand load on accept, then one bit per cycle with the result shifting in from the top
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         count <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= b_load;
         carry <= carry_init;
         count <= '0;
         sum   <= '0;
      end else if (step) begin
         sum   <= {fa_s, sum[WIDTH-1:1]};
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         carry <= fa_co;
         if (last) begin
            cout <= fa_co;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule
